// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - round-robin shared register bank
//
// Purpose: NUM_REQ requesters share one bank of 2**ADDR_W DATA_W-bit
// registers. Each grant performs exactly one read or one write. A grant
// takes two cycles: ARB samples and captures, then EXEC performs the access.
//
// Ports:
//   clk, n_rst      clock, asynchronous active-low reset
//   req, we         per-requester request level and write(1)/read(0) select
//   addr, wdata     per-requester address / write data, packed by requester
//   gnt             one-hot grant pulse, high during EXEC
//   rdata, rvalid   read data, plus a one-cycle valid pulse the cycle after EXEC
//   rid             index of the requester that owns rdata
//   busy            high during EXEC
//   bank            every register, flat; entry k is at [k*DATA_W +: DATA_W]
module reg_bank_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               we,
    input  logic [NUM_REQ*ADDR_W-1:0]        addr,
    input  logic [NUM_REQ*DATA_W-1:0]        wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [DATA_W-1:0]                rdata,
    output logic                             rvalid,
    output logic [1:0]                       rid,
    output logic                             busy,
    output logic [(2**ADDR_W)*DATA_W-1:0]    bank
);

    localparam int NUM_REG = 2**ADDR_W;
    localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);

    typedef enum logic {ARB = 1'b0, EXEC = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          w_q, w_d;
    logic                we_cap_q, we_cap_d;
    logic [ADDR_W-1:0]   addr_cap_q, addr_cap_d;
    logic [DATA_W-1:0]   wdata_cap_q, wdata_cap_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic [1:0]          rid_q, rid_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   bank_q [NUM_REG];
    logic [DATA_W-1:0]   bank_d [NUM_REG];

    // Requester vectors padded to the maximum of four so a 2-bit index
    // never selects outside the vector.
    logic [3:0]          req_ext, we_ext;
    logic [2:0]          idx;
    logic                found;
    logic [1:0]          win;

    assign req_ext = 4'(req);
    assign we_ext  = 4'(we);

    // Round-robin search: first set request at or above ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + 3'(k);
            if (idx >= 3'(NUM_REQ)) begin
                idx = idx - 3'(NUM_REQ);
            end
            if (!found && req_ext[idx[1:0]]) begin
                found = 1'b1;
                win   = idx[1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        w_d         = w_q;
        we_cap_d    = we_cap_q;
        addr_cap_d  = addr_cap_q;
        wdata_cap_d = wdata_cap_q;
        gnt_d       = '0;
        busy_d      = 1'b0;
        rvalid_d    = 1'b0;
        rdata_d     = rdata_q;
        rid_d       = rid_q;
        bank_d      = bank_q;
        case (state_q)
            ARB: begin
                if (found) begin
                    w_d         = win;
                    we_cap_d    = we_ext[win];
                    addr_cap_d  = addr[int'(win)*ADDR_W +: ADDR_W];
                    wdata_cap_d = wdata[int'(win)*DATA_W +: DATA_W];
                    // Grant and busy are registered so they coincide with EXEC.
                    gnt_d       = GNT_ONE << win;
                    busy_d      = 1'b1;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                if (we_cap_q) begin
                    bank_d[addr_cap_q] = wdata_cap_q;
                end else begin
                    rdata_d  = bank_q[addr_cap_q];
                    rid_d    = w_q;
                    rvalid_d = 1'b1;
                end
                ptr_d   = (w_q == 2'(NUM_REQ - 1)) ? 2'd0 : w_q + 2'd1;
                state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            w_q         <= '0;
            we_cap_q    <= 1'b0;
            addr_cap_q  <= '0;
            wdata_cap_q <= '0;
            gnt_q       <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            rid_q       <= '0;
            busy_q      <= 1'b0;
            for (int k = 0; k < NUM_REG; k++) begin
                bank_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            w_q         <= w_d;
            we_cap_q    <= we_cap_d;
            addr_cap_q  <= addr_cap_d;
            wdata_cap_q <= wdata_cap_d;
            gnt_q       <= gnt_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            rid_q       <= rid_d;
            busy_q      <= busy_d;
            for (int k = 0; k < NUM_REG; k++) begin
                bank_q[k] <= bank_d[k];
            end
        end
    end

    assign gnt    = gnt_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign rid    = rid_q;
    assign busy   = busy_q;

    for (genvar g = 0; g < NUM_REG; g++) begin : g_flat
        assign bank[g*DATA_W +: DATA_W] = bank_q[g];
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - directed self-checking bench for reg_bank_arbiter
module tb_reg_bank_arbiter;

    logic        clk;
    logic        n_rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [8:0]  addr;
    logic [23:0] wdata;
    logic [2:0]  gnt;
    logic [7:0]  rdata;
    logic        rvalid;
    logic [1:0]  rid;
    logic        busy;
    logic [63:0] bank;

    int vectors;
    int errors;

    reg_bank_arbiter #(.NUM_REQ(3), .ADDR_W(3), .DATA_W(8)) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rdata  (rdata),
        .rvalid (rvalid),
        .rid    (rid),
        .busy   (busy),
        .bank   (bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        repeat (3) tick();
        vectors++;
        if (rdata !== 8'h00 || rid !== 2'd0) begin
            $display("FAIL reset_rdata_rid: rdata=%h rid=%0d expected 00/0", rdata, rid);
            errors++;
        end
        n_rst = 1'b1;
        vectors++;
        if (bank !== 64'h0) begin
            $display("FAIL reset_bank: got %h expected 0", bank);
            errors++;
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if (gnt !== 3'b000 || rvalid !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL reset_idle cycle %0d: gnt=%b rvalid=%b busy=%b expected 000/0/0",
                         c, gnt, rvalid, busy);
                errors++;
            end
        end
    endtask

    task automatic test_single_write_read();
        req = 3'b001; we = 3'b001; addr[2:0] = 3'd5; wdata[7:0] = 8'hA5;
        tick();
        vectors++;
        if (gnt !== 3'b001 || busy !== 1'b1) begin
            $display("FAIL swr_write_gnt: gnt=%b busy=%b expected 001/1", gnt, busy);
            errors++;
        end
        req = 3'b000;
        tick();
        vectors++;
        if (gnt !== 3'b000 || bank[5*8 +: 8] !== 8'hA5) begin
            $display("FAIL swr_write_bank: gnt=%b bank5=%h expected 000/a5", gnt, bank[5*8 +: 8]);
            errors++;
        end
        req = 3'b001; we = 3'b000; addr[2:0] = 3'd5;
        tick();
        vectors++;
        if (gnt !== 3'b001) begin
            $display("FAIL swr_read_gnt: gnt=%b expected 001", gnt);
            errors++;
        end
        req = 3'b000;
        tick();
        vectors++;
        if (rvalid !== 1'b1 || rdata !== 8'hA5 || rid !== 2'd0) begin
            $display("FAIL swr_read_data: rvalid=%b rdata=%h rid=%0d expected 1/a5/0",
                     rvalid, rdata, rid);
            errors++;
        end
        tick();
        vectors++;
        if (rvalid !== 1'b0 || rdata !== 8'hA5) begin
            $display("FAIL swr_read_hold: rvalid=%b rdata=%h expected 0/a5", rvalid, rdata);
            errors++;
        end
    endtask

    task automatic test_fairness();
        logic [2:0] exp_gnt;
        do_reset();
        req = 3'b111; we = 3'b000; addr = '0;
        for (int i = 0; i < 6; i++) begin
            exp_gnt = 3'b001 << (i % 3);
            tick();
            vectors++;
            if (gnt !== exp_gnt || busy !== 1'b1) begin
                $display("FAIL fair_gnt %0d: gnt=%b busy=%b expected %b/1", i, gnt, busy, exp_gnt);
                errors++;
            end
            req = req & ~exp_gnt;
            tick();
            vectors++;
            if (gnt !== 3'b000) begin
                $display("FAIL fair_gap %0d: gnt=%b expected 000", i, gnt);
                errors++;
            end
            req = req | exp_gnt;
        end
        req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_ptr_continuation();
        do_reset();
        req = 3'b010; we = 3'b000;
        tick();
        vectors++;
        if (gnt !== 3'b010) begin
            $display("FAIL ptr_first: gnt=%b expected 010", gnt);
            errors++;
        end
        req = 3'b101;
        tick();
        tick();
        vectors++;
        if (gnt !== 3'b100) begin
            $display("FAIL ptr_second: gnt=%b expected 100", gnt);
            errors++;
        end
        req = 3'b001;
        tick();
        tick();
        vectors++;
        if (gnt !== 3'b001) begin
            $display("FAIL ptr_third: gnt=%b expected 001", gnt);
            errors++;
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_back_to_back();
        req = 3'b010; we = 3'b010; addr[5:3] = 3'd7; wdata[15:8] = 8'h3C;
        tick();
        vectors++;
        if (gnt !== 3'b010) begin
            $display("FAIL b2b_write_gnt: gnt=%b expected 010", gnt);
            errors++;
        end
        req = 3'b100; we = 3'b000; addr[8:6] = 3'd7;
        tick();
        vectors++;
        if (bank[7*8 +: 8] !== 8'h3C) begin
            $display("FAIL b2b_bank7: got %h expected 3c", bank[7*8 +: 8]);
            errors++;
        end
        tick();
        vectors++;
        if (gnt !== 3'b100) begin
            $display("FAIL b2b_read_gnt: gnt=%b expected 100", gnt);
            errors++;
        end
        req = 3'b000;
        tick();
        vectors++;
        if (rvalid !== 1'b1 || rdata !== 8'h3C || rid !== 2'd2) begin
            $display("FAIL b2b_read_data: rvalid=%b rdata=%h rid=%0d expected 1/3c/2",
                     rvalid, rdata, rid);
            errors++;
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        req = 3'b100; we = 3'b100; addr[8:6] = 3'd2; wdata[23:16] = 8'hFF;
        tick();
        vectors++;
        if (gnt !== 3'b100 || busy !== 1'b1) begin
            $display("FAIL rst_mid_gnt: gnt=%b busy=%b expected 100/1", gnt, busy);
            errors++;
        end
        req   = 3'b000;
        we    = 3'b000;
        n_rst = 1'b0;
        #1;
        vectors++;
        if (gnt !== 3'b000 || busy !== 1'b0) begin
            $display("FAIL rst_mid_outputs: gnt=%b busy=%b expected 000/0", gnt, busy);
            errors++;
        end
        tick();
        n_rst = 1'b1;
        tick();
        vectors++;
        if (bank[2*8 +: 8] !== 8'h00 || bank !== 64'h0) begin
            $display("FAIL rst_mid_bank: bank=%h expected 0", bank);
            errors++;
        end
        req = 3'b110;
        tick();
        vectors++;
        if (gnt !== 3'b010) begin
            $display("FAIL rst_mid_contend: gnt=%b expected 010", gnt);
            errors++;
        end
        req = 3'b000;
        tick();
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_single_write_read();
        test_fairness();
        test_ptr_continuation();
        test_back_to_back();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
Shares one bank of 2**ADDR_W byte-wide registers between NUM_REQ independent requesters, such as the Nios2 bridge, a DMA sequencer and a debug port. The bank is built from reset-to-zero D flip-flops.
- Arbitration is round-robin.
- Each granted access is a single write or a single read.
- Read data returns with a valid strobe and the index of the requester it belongs to.
- The whole bank is also exported flat so downstream logic can use the registers as static configuration.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 2..4.
- ADDR_W, 3, register address width; the bank holds 2**ADDR_W entries.
- DATA_W, 8, register width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- n_rst  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester access request, level.
- we  in  NUM_REQ  per-requester operation: 1 = write, 0 = read.
- addr  in  NUM_REQ*ADDR_W  per-requester address; requester i uses bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  per-requester write data; requester i uses bits [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot grant pulse, registered.
- rdata  out  DATA_W  read data, registered.
- rvalid  out  1  rdata valid pulse.
- rid  out  2  index of the requester owning rdata.
- busy  out  1  high while an access is in progress (state EXEC).
- bank  out  (2**ADDR_W)*DATA_W  all registers, flat; entry k is at [k*DATA_W +: DATA_W].

Behaviour:
- Reset (n_rst low, asynchronous):
  - all bank entries 0;
  - gnt 0, rdata 0, rvalid 0, rid 0, busy 0;
  - state ARB, round-robin pointer ptr 0.
- FSM has two states, ARB and EXEC.
- ARB, cycle N:
  - If req == 0, stay in ARB.
  - Otherwise select the winner w: the first set req bit found searching from index ptr upward, wrapping modulo NUM_REQ.
  - Capture w, we[w], addr[w] and wdata[w] into internal registers, then go to EXEC.
- EXEC, cycle N+1:
  - gnt[w] = 1 for exactly this cycle; busy = 1.
  - A write updates bank[addr] at the end of N+1, so the new value is visible on bank in N+2.
  - A read loads rdata with bank[addr] at the end of N+1 and sets rid = w. rvalid = 1 for exactly cycle N+2; rdata holds its value until the next read.
  - ptr updates to (w+1) mod NUM_REQ.
  - Return to ARB.
- Throughput is one access per 2 cycles. Read latency is 2 cycles from the ARB sample to rvalid.
- Requester contract:
  - Hold req, we, addr and wdata stable until gnt is seen high.
  - Deassert req, or present the next request, in the cycle after gnt.
  - Because gnt is registered, the ARB cycle that follows sees the updated req.
- Withdrawal:
  - If req drops before the ARB sample, no access occurs.
  - Changes during EXEC are ignored, because the access uses the captured values.
- Back-to-back: a read issued in the ARB cycle immediately after a write to the same address returns the newly written value (the write landed at the end of the previous EXEC).
- The rvalid pulse in N+2 may coincide with the next ARB decision; the two are independent.
- Unused req bits above NUM_REQ do not exist. rid values 0..NUM_REQ-1 only.
- Reset asserted during EXEC:
  - the access is aborted; a pending write does not occur;
  - outputs return to reset values immediately;
  - after release, the FSM starts in ARB with ptr 0.
- Only one registered write port drives the bank, so no two writes can occur in the same cycle.

Test Plan:
- Reset: hold n_rst low 3 cycles, then release with req=0 -> bank all 0; gnt, rvalid and busy 0 for 10 cycles; state stays idle.
- Single write/read: req0 writes addr 5 = 0xA5 -> gnt=3'b001 one cycle later, bank[5]=0xA5 the cycle after. req0 then reads addr 5 -> rvalid pulse with rdata=0xA5, rid=0.
- Fairness: req=3'b111 held, with each requester dropping after its gnt and re-raising -> grant order 0,1,2,0,1,2. Each gnt is exactly one cycle and grants are 2 cycles apart.
- Pointer continuation: grant req1 alone, then raise req0 and req2 together -> req2 is granted first, then req0.
- Read-after-write: req1 writes addr 7 = 0x3C, then req2 reads addr 7 in the next ARB -> rdata=0x3C, rid=2.
- Reset mid-access: req2 writes addr 2 = 0xFF and n_rst is pulsed low during its EXEC cycle -> bank[2]=0, gnt=0. The first post-reset contention with req=3'b110 grants req1.
